// File: rtl/meas_snapshot_if.sv
// Bundle of the meas_snapshot control, result and CSR read-port signals.
// Port summary (directions seen from the slave, i.e. the meas_snapshot core):
//   test_start_i, test_done_i   in   1-cycle test begin / last-transaction pulses
//   meas_busy_i                 in   high = measurement block has nothing in flight
//   meas_result_i               in   RES_NUM x 32-bit live result words, word 0 in [31:0]
//   csr_addr_i, csr_read_i      in   read word address and strobe
//   csr_readdata_o              out  read data
//   csr_readdatavalid_o         out  read data valid, one cycle after the strobe
//   snapshot_valid_o            out  snapshot bank holds the last finished test
//   test_running_o              out  a test is in progress
// master: driver of the inputs (test sequencer / CSR block); slave: meas_snapshot.
interface meas_snapshot_if #(
  parameter int unsigned RES_NUM    = 8,
  parameter int unsigned CSR_ADDR_W = 4
);
  logic                    test_start_i;
  logic                    test_done_i;
  logic                    meas_busy_i;
  logic [RES_NUM*32-1:0]   meas_result_i;
  logic [CSR_ADDR_W-1:0]   csr_addr_i;
  logic                    csr_read_i;
  logic [31:0]             csr_readdata_o;
  logic                    csr_readdatavalid_o;
  logic                    snapshot_valid_o;
  logic                    test_running_o;

  modport master (
    output test_start_i, test_done_i, meas_busy_i, meas_result_i, csr_addr_i, csr_read_i,
    input  csr_readdata_o, csr_readdatavalid_o, snapshot_valid_o, test_running_o
  );

  modport slave (
    input  test_start_i, test_done_i, meas_busy_i, meas_result_i, csr_addr_i, csr_read_i,
    output csr_readdata_o, csr_readdatavalid_o, snapshot_valid_o, test_running_o
  );
endinterface

// File: rtl/meas_snapshot.sv
// meas_snapshot: tracks a test run, waits for the measurement pipeline to drain after the
// last transaction, then freezes all result words into a snapshot bank readable over a
// 1-cycle-latency CSR read port (words 0..RES_NUM-1, status at RES_NUM, avg at RES_NUM+1).
// Ports:
//   clk_i  clock
//   rst_i  asynchronous reset, active-high
//   bus    meas_snapshot_if.slave (test pulses, meas_busy_i, result bus, CSR read port,
//          snapshot_valid_o, test_running_o)
// Status word: [0] snapshot valid, [1] drain timeout, [2] test running, [3] divider busy.
// Optional feature: define MEAS_SNAPSHOT_AVG_DEL_EN to add a DIV state computing
// avg = SUM_DEL / RD_REQ with a 32-cycle restoring divider (divisor 0 -> all ones).
module meas_snapshot #(
  parameter int unsigned RES_NUM       = 8,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter int unsigned IDLE_CONFIRM  = 3,
  parameter int unsigned CSR_ADDR_W    = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  meas_snapshot_if.slave bus
);

  localparam int unsigned DrainW = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int unsigned IdleW  = $clog2(IDLE_CONFIRM + 1);

`ifdef MEAS_SNAPSHOT_AVG_DEL_EN
  // SUM_DEL and RD_REQ are the last two words in package order.
  localparam int unsigned SumDelIdx = RES_NUM - 2;
  localparam int unsigned RdReqIdx  = RES_NUM - 1;
  typedef enum logic [2:0] {StIdle, StRun, StDrain, StDiv, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StRun, StDrain, StDone} state_e;
`endif

  state_e              state_q;
  logic [31:0]         bank_q [RES_NUM];
  logic [DrainW-1:0]   drain_cnt_q;
  logic [IdleW-1:0]    idle_cnt_q;
  logic                valid_q;
  logic                timeout_q;
  logic                running_q;
  logic                div_busy;

  logic [IdleW-1:0]    idle_next;
  logic                idle_hit;
  logic                to_hit;

  assign idle_next = bus.meas_busy_i ? idle_cnt_q + IdleW'(1) : '0;
  assign idle_hit  = (idle_next == IdleW'(IDLE_CONFIRM));
  assign to_hit    = (drain_cnt_q == DrainW'(DRAIN_TIMEOUT - 1));

`ifdef MEAS_SNAPSHOT_AVG_DEL_EN
  logic [31:0] avg_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [4:0]  div_cnt_q;
  logic [31:0] divisor;
  logic [32:0] trial;
  logic        trial_ge;
  logic [31:0] rem_step;
  logic [31:0] quo_step;

  // Restoring step: shift the next dividend bit (MSB of quo_q) into the remainder.
  // The true difference always fits 32 bits, so the low-word subtraction is exact.
  assign divisor  = bank_q[RdReqIdx];
  assign trial    = {rem_q, quo_q[31]};
  assign trial_ge = (trial >= {1'b0, divisor});
  assign rem_step = trial_ge ? (trial[31:0] - divisor) : trial[31:0];
  assign quo_step = {quo_q[30:0], trial_ge};
  assign div_busy = (state_q == StDiv);
`else
  assign div_busy = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      for (int k = 0; k < RES_NUM; k++) bank_q[k] <= '0;
      drain_cnt_q <= '0;
      idle_cnt_q  <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      running_q   <= 1'b0;
`ifdef MEAS_SNAPSHOT_AVG_DEL_EN
      avg_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_cnt_q   <= '0;
`endif
    end else if (bus.test_start_i) begin
      // A new test restarts from any state; the bank is kept until the next capture.
      state_q     <= StRun;
      drain_cnt_q <= '0;
      idle_cnt_q  <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      running_q   <= 1'b1;
`ifdef MEAS_SNAPSHOT_AVG_DEL_EN
      avg_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.test_done_i) begin
            state_q     <= StDrain;
            drain_cnt_q <= '0;
            idle_cnt_q  <= '0;
          end
        end
        StDrain: begin
          idle_cnt_q  <= idle_next;
          drain_cnt_q <= drain_cnt_q + DrainW'(1);
          if (idle_hit || to_hit) begin
            for (int k = 0; k < RES_NUM; k++) bank_q[k] <= bus.meas_result_i[32*k +: 32];
            // A confirmed idle in the same cycle makes the timeout moot.
            timeout_q <= to_hit && !idle_hit;
`ifdef MEAS_SNAPSHOT_AVG_DEL_EN
            state_q   <= StDiv;
            rem_q     <= '0;
            quo_q     <= bus.meas_result_i[32*SumDelIdx +: 32];
            div_cnt_q <= '0;
`else
            state_q   <= StDone;
            running_q <= 1'b0;
            valid_q   <= 1'b1;
`endif
          end
        end
`ifdef MEAS_SNAPSHOT_AVG_DEL_EN
        StDiv: begin
          if (divisor == 32'h0) begin
            avg_q     <= 32'hFFFF_FFFF;
            state_q   <= StDone;
            running_q <= 1'b0;
            valid_q   <= 1'b1;
          end else begin
            rem_q     <= rem_step;
            quo_q     <= quo_step;
            div_cnt_q <= div_cnt_q + 5'd1;
            if (div_cnt_q == 5'd31) begin
              avg_q     <= quo_step;
              state_q   <= StDone;
              running_q <= 1'b0;
              valid_q   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          // StIdle waits for test_start_i; StDone holds; test_done_i is ignored here.
        end
      endcase
    end
  end

  // CSR read port: data and valid both registered, one cycle after the strobe.
  logic [31:0] status;
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;
  logic        rvalid_q;

  assign status = {28'h0, div_busy, running_q, timeout_q, valid_q};

  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < RES_NUM; k++) begin
      if (bus.csr_addr_i == CSR_ADDR_W'(k)) rdata_d = bank_q[k];
    end
    if (bus.csr_addr_i == CSR_ADDR_W'(RES_NUM)) rdata_d = status;
`ifdef MEAS_SNAPSHOT_AVG_DEL_EN
    if (bus.csr_addr_i == CSR_ADDR_W'(RES_NUM + 1)) rdata_d = avg_q;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= bus.csr_read_i;
      rdata_q  <= bus.csr_read_i ? rdata_d : '0;
    end
  end

  assign bus.csr_readdata_o      = rdata_q;
  assign bus.csr_readdatavalid_o = rvalid_q;
  assign bus.snapshot_valid_o    = valid_q;
  assign bus.test_running_o      = running_q;

endmodule

// File: tb/tb_meas_snapshot.sv
// Self-checking bench for meas_snapshot (DRAIN_TIMEOUT = 16). A behavioural model derives
// the capture cycle from the busy pattern (first window of IDLE_CONFIRM ones, or the
// timeout cycle), the captured words, the status word and the average.
module tb_meas_snapshot;
  localparam int DT = 16;
  localparam int IC = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  meas_snapshot_if #(.RES_NUM(8), .CSR_ADDR_W(4)) bus ();

  meas_snapshot #(
    .RES_NUM(8), .DRAIN_TIMEOUT(DT), .IDLE_CONFIRM(IC), .CSR_ADDR_W(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_bank [8];
  logic [31:0] exp_avg;
  logic        exp_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st(input bit v, input bit t, input bit r, input bit d);
    return {28'h0, d, r, t, v};
  endfunction

  task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    bus.csr_addr_i = addr;
    bus.csr_read_i = 1'b1;
    tick();
    bus.csr_read_i = 1'b0;
    chk({tag, "_rvld"}, 32'(bus.csr_readdatavalid_o), 32'h1);
    chk(tag, bus.csr_readdata_o, exp);
  endtask

  task automatic pulse_start();
    bus.test_start_i = 1'b1;
    tick();
    bus.test_start_i = 1'b0;
  endtask

  task automatic pulse_done();
    bus.test_done_i = 1'b1;
    tick();
    bus.test_done_i = 1'b0;
  endtask

  // mode 0: random words (RD_REQ small non-zero); 1: word k = 0x100+k;
  // 2: as 1 with SUM_DEL / RD_REQ overridden.
  task automatic run_test(input logic [31:0] bpat, input int mode, input logic [31:0] sum_ov,
                          input logic [31:0] rd_ov, input string tag);
    int cap;
    int dlen;
    logic [31:0] w [8];
    cap    = DT - 1;
    exp_to = 1'b1;
    for (int i = IC - 1; i < DT; i++) begin
      bit all1;
      all1 = 1'b1;
      for (int j = 0; j < IC; j++) if (!bpat[i-j]) all1 = 1'b0;
      if (all1) begin
        cap    = i;
        exp_to = 1'b0;
        break;
      end
    end

    pulse_start();
    chk({tag, "_run"}, 32'(bus.test_running_o), 32'h1);
    chk({tag, "_vld0"}, 32'(bus.snapshot_valid_o), 32'h0);
    repeat ($urandom_range(3, 0)) begin
      bus.meas_busy_i = 1'($urandom_range(1, 0));
      tick();
    end
    pulse_done();

    for (int i = 0; i <= cap; i++) begin
      bus.meas_busy_i = bpat[i];
      for (int k = 0; k < 8; k++) w[k] = (mode == 0) ? $urandom : 32'h100 + 32'(k);
      if (mode == 0) w[7] = 32'($urandom_range(300, 1));
      if (mode == 2) begin
        w[6] = sum_ov;
        w[7] = rd_ov;
      end
      for (int k = 0; k < 8; k++) bus.meas_result_i[32*k +: 32] = w[k];
      if (i == cap) exp_bank = w;
      tick();
      if (i < cap) chk($sformatf("%s_drain%0d_vld", tag, i), 32'(bus.snapshot_valid_o), 32'h0);
    end

`ifdef MEAS_SNAPSHOT_AVG_DEL_EN
    dlen    = (exp_bank[7] == 32'h0) ? 1 : 32;
    exp_avg = (exp_bank[7] == 32'h0) ? 32'hFFFF_FFFF : exp_bank[6] / exp_bank[7];
`else
    dlen    = 0;
    exp_avg = 32'h0;
`endif
    for (int j = 0; j < dlen; j++) begin
      chk($sformatf("%s_div%0d_vld", tag, j), 32'(bus.snapshot_valid_o), 32'h0);
      tick();
    end
    chk({tag, "_vld1"}, 32'(bus.snapshot_valid_o), 32'h1);
    chk({tag, "_run_end"}, 32'(bus.test_running_o), 32'h0);

    for (int k = 0; k < 8; k++) rd(4'(k), exp_bank[k], $sformatf("%s_w%0d", tag, k));
    rd(4'd8, st(1'b1, exp_to, 1'b0, 1'b0), {tag, "_status"});
    rd(4'd9, exp_avg, {tag, "_avg"});
    rd(4'd12, 32'h0, {tag, "_addr12"});
  endtask

  initial begin
    rst                = 1'b1;
    bus.test_start_i   = 1'b0;
    bus.test_done_i    = 1'b0;
    bus.meas_busy_i    = 1'b0;
    bus.meas_result_i  = '0;
    bus.csr_addr_i     = '0;
    bus.csr_read_i     = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state.
    chk("rst_vld", 32'(bus.snapshot_valid_o), 32'h0);
    chk("rst_run", 32'(bus.test_running_o), 32'h0);
    rd(4'd8, 32'h0, "rst_status");

    // test_done_i while idle is ignored.
    pulse_done();
    chk("idle_done_run", 32'(bus.test_running_o), 32'h0);

    // Steady idle: capture on the third DRAIN cycle.
    run_test(32'hFFFF_FFFF, 1, 32'h0, 32'h0, "steady");

    // test_done_i in DONE is ignored.
    pulse_done();
    chk("done_done_vld", 32'(bus.snapshot_valid_o), 32'h1);
    rd(4'd8, 32'h1, "done_done_status");

    // Busy drops once: capture on the sixth cycle.
    run_test(32'h0000_003B, 1, 32'h0, 32'h0, "toggle");

    // Never idle: forced capture at timeout.
    run_test(32'h0, 0, 32'h0, 32'h0, "timeout");

    // Reset in the middle of DRAIN.
    pulse_start();
    pulse_done();
    bus.meas_busy_i = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(bus.snapshot_valid_o), 32'h0);
    chk("mid_rst_run", 32'(bus.test_running_o), 32'h0);
    chk("mid_rst_rvld", 32'(bus.csr_readdatavalid_o), 32'h0);
    chk("mid_rst_rdata", bus.csr_readdata_o, 32'h0);
    tick();
    rst = 1'b0;
    rd(4'd8, 32'h0, "mid_rst_status");
    rd(4'd0, 32'h0, "mid_rst_w0");

    // Average delay, including a zero divisor.
    run_test(32'hFFFF_FFFF, 2, 32'd1000, 32'd7, "avg");
    run_test(32'hFFFF_FFFF, 2, 32'd1000, 32'd0, "avg_div0");

    // Restart right after capture (inside DIV when the divider is present).
    pulse_start();
    pulse_done();
    bus.meas_busy_i = 1'b1;
    for (int k = 0; k < 8; k++) bus.meas_result_i[32*k +: 32] = 32'h200 + 32'(k);
    bus.meas_result_i[32*7 +: 32] = 32'd5;
    repeat (3) tick();
    repeat (2) tick();
`ifdef MEAS_SNAPSHOT_AVG_DEL_EN
    rd(4'd8, st(1'b0, 1'b0, 1'b1, 1'b1), "restart_pre_status");
`else
    rd(4'd8, st(1'b1, 1'b0, 1'b0, 1'b0), "restart_pre_status");
`endif
    pulse_start();
    chk("restart_run", 32'(bus.test_running_o), 32'h1);
    chk("restart_vld", 32'(bus.snapshot_valid_o), 32'h0);
    rd(4'd8, st(1'b0, 1'b0, 1'b1, 1'b0), "restart_status");
    rd(4'd9, 32'h0, "restart_avg");
    rd(4'd12, 32'h0, "restart_addr12");
    rd(4'd0, 32'h200, "restart_bank_kept");

    // Randomized busy patterns and result words.
    for (int r = 0; r < 6; r++) run_test($urandom, 0, 32'h0, 32'h0, $sformatf("rand%0d", r));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
